// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment readback path.
// Glyphs are active-low {g,f,e,d,c,b,a}; SEG_GLYPH[n] is the pattern for hex digit n.
package seg_pkg;

    typedef logic [3:0] nibble_t;

    typedef enum logic {
        SETTLE,
        HELD
    } cap_state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg_to_hex_lut.sv
// Combinational inverse of the hex-to-segment decoder.
// hit flags a known glyph; blank flags the all-off pattern.
module seg_to_hex_lut
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic       hit,
    output nibble_t    nibble,
    output logic       blank
);

    always_comb begin
        hit    = 1'b0;
        nibble = '0;
        blank  = (seg == SEG_BLANK);
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_GLYPH[i]) begin
                hit    = 1'b1;
                nibble = nibble_t'(i);
            end
        end
    end

endmodule

// File: rtl/seg_capture.sv
// Passive seven-segment readback monitor: debounces each (digit_sel, seg) pair
// and commits one decoded nibble per digit after STABLE_CYCLES identical samples.
module seg_capture
    import seg_pkg::*;
#(
    parameter  int NUM_DIGITS    = 6,
    parameter  int STABLE_CYCLES = 4,
    localparam int IDX_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
    localparam int CNT_W         = (STABLE_CYCLES > 0) ? $clog2(STABLE_CYCLES + 1) : 1
)
(
    input  logic                    clock,
    input  logic                    resetn,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   digit_sel,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic [NUM_DIGITS-1:0]   valid,
    output logic                    update,
    output logic [IDX_W-1:0]        update_idx,
    output logic                    pattern_err,
    output logic                    sel_err
);

    localparam int                SW       = NUM_DIGITS + 7;
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [SW-1:0]     S_RESET  = {{NUM_DIGITS{1'b0}}, SEG_BLANK};

    logic [SW-1:0]         s_q;
    logic [SW-1:0]         live;
    logic [CNT_W-1:0]      cnt;
    logic                  match;
    cap_state_e            state_q;
    cap_state_e            state_d;

    logic [NUM_DIGITS-1:0] sel_q;
    logic [6:0]            seg_q;
    logic                  lut_hit;
    nibble_t               lut_nibble;
    logic                  lut_blank;

    logic                  commit;
    logic                  one_hot;
    logic                  do_update;
    logic                  do_pattern_err;
    logic                  do_sel_err;
    logic [IDX_W-1:0]      commit_idx;

    assign live  = {digit_sel, seg};
    assign match = (live == s_q);
    assign sel_q = s_q[SW-1:7];
    assign seg_q = s_q[6:0];

    // Decoding works on the registered sample, so outputs never see raw inputs.
    seg_to_hex_lut u_lut (
        .seg    (seg_q),
        .hit    (lut_hit),
        .nibble (lut_nibble),
        .blank  (lut_blank)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s_q <= S_RESET;
            cnt <= '0;
        end else begin
            s_q <= live;
            if (!match) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= SETTLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!match) begin
            state_d = SETTLE;
        end else if (commit) begin
            state_d = HELD;
        end
    end

    // A commit only happens while settling, so a held input never re-commits.
    always_comb begin
        commit         = (state_q == SETTLE) && match && (cnt == CNT_LAST);
        one_hot        = $onehot(sel_q);
        commit_idx     = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel_q[i]) begin
                commit_idx = IDX_W'(i);
            end
        end
        do_update      = commit && one_hot;
        do_sel_err     = commit && (sel_q != '0) && !one_hot;
        do_pattern_err = do_update && !lut_hit && !lut_blank;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            value       <= '0;
            valid       <= '0;
            update      <= 1'b0;
            update_idx  <= '0;
            pattern_err <= 1'b0;
            sel_err     <= 1'b0;
        end else begin
            update      <= do_update;
            pattern_err <= do_pattern_err;
            sel_err     <= do_sel_err;
            if (do_update) begin
                update_idx <= commit_idx;
            end
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (do_update && sel_q[i]) begin
                    valid[i] <= lut_hit;
                    if (lut_hit) begin
                        value[4*i +: 4] <= lut_nibble;
                    end
                end
            end
        end
    end

endmodule

// File: doc/seg_capture.md
# seg_capture

Passive reader for the multiplexed seven-segment output path: watches an active-low 7-bit segment bus plus a one-hot digit-select strobe, debounces each (select, pattern) pair, maps the pattern back to a 4-bit hex value, and holds one nibble per display digit. It is the inverse of the hex-to-segment display decoder. It sits beside the HEX driver logic as a self-check and score/readback monitor, and is the reference model for display-path verification.

## Interface

- NUM_DIGITS, 6: number of display digits tracked (HEX0..HEX5).
- STABLE_CYCLES, 4: consecutive identical samples required before commit; legal range ≥1.

- clock  in  1  system clock; all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- seg  in  7  segment bus, active-low, bit0=a … bit6=g (0 = lit).
- digit_sel  in  NUM_DIGITS  active-high select; bit i = seg currently drives digit i.
- value  out  4*NUM_DIGITS  decoded nibbles; digit i at [4i+3:4i]; reset 0.
- valid  out  NUM_DIGITS  digit i holds a decoded value; reset 0.
- update  out  1  one-cycle pulse on every commit; reset 0.
- update_idx  out  clog2(NUM_DIGITS)  digit index of the last commit; reset 0.
- pattern_err  out  1  one-cycle pulse: committed pattern not a hex glyph; reset 0.
- sel_err  out  1  one-cycle pulse: stable digit_sel not one-hot and not zero; reset 0.

## Operation

- Glyph table, active-low {g..a}: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex). Blank = 7F.
- Sample register s_q holds {digit_sel, seg}; loads every cycle. Reset value: digit_sel 0, seg 7F.
- Stability counter cnt, width clog2(STABLE_CYCLES+1), saturates at STABLE_CYCLES. If the live input ≠ s_q, cnt ← 0; otherwise cnt increments while below STABLE_CYCLES.
- States: SETTLE (cnt < STABLE_CYCLES) and HELD (cnt = STABLE_CYCLES). Commit fires on the edge where cnt = STABLE_CYCLES−1 and the live input = s_q; that edge moves SETTLE→HELD. Any input change returns the block to SETTLE.
- Exactly one commit per stable period. A held input never re-commits.
- Commit action, by s_q.digit_sel:
  - All zero (blanking gap): no commit action, no pulses; the state still moves to HELD.
  - Multi-hot: sel_err pulse; value, valid, update unchanged.
  - One-hot digit i, seg = known glyph: value[i] ← nibble, valid[i] ← 1, update pulse, update_idx ← i.
  - One-hot, seg = 7F: valid[i] ← 0, value[i] retained, update pulse, no error.
  - One-hot, seg = other pattern: valid[i] ← 0, value[i] retained, update pulse, pattern_err pulse.
- Other digits are never disturbed by a commit.

## Timing

- Input X first present before edge e0: s_q ← X at e0, cnt ← 0. Commit occurs at edge e(STABLE_CYCLES). value/valid/pulses are visible after that edge; pulses last exactly one cycle.
- STABLE_CYCLES = 1: commit one edge after first sampling.
- An input change at or before the commit edge aborts the commit. The new value restarts the count from 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- resetn low at any time, including mid-settle: all registers go to reset values immediately. The first commit after release needs a full STABLE_CYCLES run.

## Structure

- Package seg_pkg: SEG_GLYPH[16] constants (table above), SEG_BLANK = 7'h7F, and a nibble_t typedef.
- Sub-module seg_to_hex_lut: combinational, seg[6:0] → {hit, nibble[3:0], blank}. It is the single place the glyph table is decoded and is reused by other checkers.
- Top level holds s_q, cnt, the state, per-digit value/valid registers, and the pulse registers.

## Test plan

- Reset, then digit_sel=000001 and seg=30 held for 4 cycles → update at e4, value[3:0]=3, valid=000001, update_idx=0, no errors.
- Scan digits 0–5 with glyphs 40, 79, 24, 08, 46, 0E, each held 6 cycles with 2-cycle zero-select gaps → value=24'hFCA210, valid=3F, six update pulses, none during gaps.
- seg toggles 12↔10 every 3 cycles on digit 2 for 20 cycles → no update. Then hold 10 → value[11:8]=9 after 4 cycles.
- digit 1 valid=A, then stable seg=7F → valid[1]=0, value[7:4]=A, no error. Stable seg=55 → pattern_err pulse, valid[1]=0.
- digit_sel=000011 stable 4 cycles → sel_err single pulse, outputs unchanged. Hold 10 more cycles → no further pulses.
- resetn asserted at cnt=2 mid-settle → all outputs 0 asynchronously. After release with the same input held, commit occurs exactly 4 edges after the first sampling edge.
